// File: rtl/sparse_pair_gather.sv
// sparse_pair_gather: feeder for the unstructured-sparse dot-product unit.
// Takes one compressed tile per side (nonzero bitmap plus packed nonzero
// values), walks the matched positions in ascending order and emits one
// operand pair per enabled cycle, with a 2-bit presence qualifier and an
// end-of-tile marker.
// Optional build macro: UNION_MODE_EN -- walk the union of the bitmaps
// instead of the intersection and report per-operand presence, driving an
// absent operand as 0.
module sparse_pair_gather #(
  parameter int DW_DATA = 8,
  parameter int VEC_LEN = 8,
  parameter int IDX_W   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       tile_valid,
  output logic                       tile_ready,
  input  logic [VEC_LEN-1:0]         bmp_a,
  input  logic [VEC_LEN-1:0]         bmp_b,
  input  logic [VEC_LEN*DW_DATA-1:0] val_a,
  input  logic [VEC_LEN*DW_DATA-1:0] val_b,
  output logic [DW_DATA-1:0]         out_a,
  output logic [DW_DATA-1:0]         out_b,
  output logic [1:0]                 out_valid,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                     r_state;
  logic [VEC_LEN-1:0]         r_bmp_a;
  logic [VEC_LEN-1:0]         r_bmp_b;
  logic [VEC_LEN*DW_DATA-1:0] r_val_a;
  logic [VEC_LEN*DW_DATA-1:0] r_val_b;
  logic [VEC_LEN-1:0]         r_pending;
  logic                       r_tile_ready;
  logic                       r_busy;
  logic [DW_DATA-1:0]         r_out_a;
  logic [DW_DATA-1:0]         r_out_b;
  logic [1:0]                 r_out_valid;
  logic [IDX_W-1:0]           r_out_idx;
  logic                       r_out_last;

  logic [VEC_LEN-1:0]         w_accept_mask;
  logic [IDX_W-1:0]           w_idx;
  logic [IDX_W-1:0]           w_cnt_a;
  logic [IDX_W-1:0]           w_cnt_b;
  logic [VEC_LEN-1:0]         w_pending_next;
  logic                       w_has_a;
  logic                       w_has_b;
  logic [DW_DATA-1:0]         w_op_a;
  logic [DW_DATA-1:0]         w_op_b;

  // Positions to visit for a newly presented tile.
  always_comb begin
`ifdef UNION_MODE_EN
    w_accept_mask = bmp_a | bmp_b;
`else
    w_accept_mask = bmp_a & bmp_b;
`endif
  end

  // Pick the lowest pending position and fetch its packed operands.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_idx   = '0;
    w_cnt_a = '0;
    w_cnt_b = '0;
    // Scan from the top down so the last hit is the lowest set bit.
    for (int i = VEC_LEN - 1; i >= 0; i--) begin
      if (r_pending[i]) w_idx = IDX_W'(i);
    end
    // Rank of position w_idx within each bitmap = packed entry number.
    for (int i = 0; i < VEC_LEN - 1; i++) begin
      if (IDX_W'(i) < w_idx) begin
        w_cnt_a = w_cnt_a + {{(IDX_W-1){1'b0}}, r_bmp_a[i]};
        w_cnt_b = w_cnt_b + {{(IDX_W-1){1'b0}}, r_bmp_b[i]};
      end
    end
    w_pending_next        = r_pending;
    w_pending_next[w_idx] = 1'b0;
    w_has_a = r_bmp_a[w_idx];
    w_has_b = r_bmp_b[w_idx];
    w_op_a  = w_has_a ? r_val_a[w_cnt_a*DW_DATA +: DW_DATA] : '0;
    w_op_b  = w_has_b ? r_val_b[w_cnt_b*DW_DATA +: DW_DATA] : '0;
  end

  // Tile acceptance, pair sequencing and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the tile store is a handful of flops, not a RAM, so it is
      // cleared on reset like every other register.
      r_state      <= S_IDLE;
      r_bmp_a      <= '0;
      r_bmp_b      <= '0;
      r_val_a      <= '0;
      r_val_b      <= '0;
      r_pending    <= '0;
      r_tile_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_out_a      <= '0;
      r_out_b      <= '0;
      r_out_valid  <= 2'b00;
      r_out_idx    <= '0;
      r_out_last   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge value of the others, independent of statement order.
      case (r_state)
        S_IDLE: begin
          r_out_valid <= 2'b00;
          r_out_last  <= 1'b0;
          if (tile_valid) begin
            r_bmp_a      <= bmp_a;
            r_bmp_b      <= bmp_b;
            r_val_a      <= val_a;
            r_val_b      <= val_b;
            r_pending    <= w_accept_mask;
            r_state      <= S_RUN;
            r_tile_ready <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        S_RUN: begin
          if (!enable) begin
            // Stall: drop the qualifiers so a held pair is never re-counted.
            r_out_valid <= 2'b00;
            r_out_last  <= 1'b0;
          end else if (r_pending == '0) begin
            // Nothing matched: one marker cycle closes the tile.
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_valid  <= 2'b00;
            r_out_idx    <= '0;
            r_out_last   <= 1'b1;
            r_state      <= S_IDLE;
            r_tile_ready <= 1'b1;
            r_busy       <= 1'b0;
          end else begin
            r_out_a     <= w_op_a;
            r_out_b     <= w_op_b;
            r_out_valid <= {w_has_a, w_has_b};
            r_out_idx   <= w_idx;
            r_out_last  <= (w_pending_next == '0);
            r_pending   <= w_pending_next;
            if (w_pending_next == '0) begin
              r_state      <= S_IDLE;
              r_tile_ready <= 1'b1;
              r_busy       <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_tile_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign tile_ready = r_tile_ready;
  assign busy       = r_busy;
  assign out_a      = r_out_a;
  assign out_b      = r_out_b;
  assign out_valid  = r_out_valid;
  assign out_idx    = r_out_idx;
  assign out_last   = r_out_last;

endmodule
